lbp_code_gen: RTL and testbench
===============================

Name: lbp_code_gen

Overview:
Downstream consumer of the bilinear interpolation stage in the LBP pipeline. It merges the four interpolated diagonal samples (Q16 fixed point, 32-bit) with the four axial neighbours and the centre pixel. The axial and centre pixels come straight from the window stage and are delayed internally to match the interpolator latency. It rounds and saturates the diagonal samples, thresholds all eight neighbours against the centre, and emits the 8-bit LBP code, a uniformity flag and per-frame end markers.

Parameters:
ALIGN, 3, cycles between done_i of a pixel and interp_done_i of the same pixel (interpolator latency)
PIX_COUNT, 65536, codes per frame (IMG_W*IMG_H); frame_done_o marks the last one
U_MAX, 2, max circular bit transitions for a code to count as uniform

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
done_i  in  1  valid for center_i/n0_i/n2_i/n4_i/n6_i this cycle
center_i  in  8  centre pixel
n0_i  in  8  axial neighbour 0 deg
n2_i  in  8  axial neighbour 90 deg
n4_i  in  8  axial neighbour 180 deg
n6_i  in  8  axial neighbour 270 deg
interp_done_i  in  1  valid for d1_i..d7_i this cycle
d1_i  in  32  interpolated 45 deg, Q16 (value<<16)
d3_i  in  32  interpolated 135 deg
d5_i  in  32  interpolated 225 deg
d7_i  in  32  interpolated 315 deg
code_o  out  8  LBP code {b7..b0}
uniform_o  out  1  1 when circular transitions of code_o <= U_MAX
done_o  out  1  one-cycle pulse, code_o/uniform_o valid
frame_done_o  out  1  pulse coincident with done_o of the PIX_COUNT-th code
align_err_o  out  1  sticky alignment error

Behaviour:
- Reset (rst=1 at an edge): code_o=0, uniform_o=0, done_o=0, frame_done_o=0, align_err_o=0. The delay line, all pipeline valids and the pixel counter clear. In-flight pixels are discarded, and no done_o is issued for them after rst deasserts.
- Delay line: ALIGN-deep shift register carrying {done_i, center_i, n0_i, n2_i, n4_i, n6_i}. It advances every cycle with no stall. The tap is the aligned set.
- Alignment check: each cycle the aligned done is compared with interp_done_i. On mismatch, align_err_o is set the next cycle and held until rst. The pipeline advances only on interp_done_i. An aligned done without interp_done_i is dropped.
- Rounding of dk: p = (dk + 0x8000) >> 16, computed 33-bit. If p > 255 then p = 255.
- Threshold: bit = (neighbour >= centre), unsigned 8-bit.
- Bit order: b0=n0, b1=d1, b2=n2, b3=d3, b4=n4, b5=d5, b6=n6, b7=d7.
- Transitions: T = count over i=0..7 of (b_i != b_((i+1) mod 8)), range 0..8. uniform = (T <= U_MAX).
- Pipeline, with interp_done_i sampled at edge t:
  - S1 (edge t): register rounded d's and aligned axial/centre.
  - S2 (edge t+1): register the 8 bits.
  - S3 (edge t+2): register code, T and uniform to the outputs, done_o=1.
  - Outputs are visible in the cycle after edge t+2, i.e. latency 3 cycles from interp_done_i.
- Throughput: one pixel per cycle. Back-to-back valids are fully supported.
- code_o/uniform_o hold their last value when done_o=0.
- Frame counter: 0..PIX_COUNT-1, increments on each done_o. On the count PIX_COUNT-1, frame_done_o=1 with that done_o and the counter wraps to 0. No other pulse.
- rst asserted simultaneously with a valid: reset wins.

Test Plan:
- centre=100, n0=100, n2=99, n4=200, n6=50, d1=0x00640000, d3=0x00637FFF, d5=0x00638000, d7=0x01000000, valid per ALIGN -> done_o 3 cycles after interp_done_i, code_o=0xB3, uniform_o=0 (T=4). This checks tie, round-down, round-up and saturate.
- centre=0, all axial=0, all d=0 -> code_o=0xFF, uniform_o=1. Next: centre=255, n0=255, all others 0 -> code_o=0x01, uniform_o=1 (T=2).
- Input 255 through weights summing to 0xFFFE (d=0x00FEFE02) with centre=255 -> rounds to 255, bit=1.
- 10 back-to-back pixels with distinct centres -> 10 consecutive done_o pulses in order, codes match a model, align_err_o=0.
- interp_done_i pulse with no done_i ALIGN cycles earlier -> align_err_o=1 next cycle, remains 1 through further valid traffic until rst.
- PIX_COUNT=4: 9 pixels -> frame_done_o on the 4th and 8th done_o only. Separately, rst pulsed 1 cycle after interp_done_i -> no done_o follows, all outputs 0, counter restarts at 0.

Source files
------------

// File: rtl/lbp_code_gen.sv
// LBP code generator: merges four interpolated diagonal samples (Q16) with
// four axial neighbours and the centre pixel. It then emits the 8-bit LBP
// code, a uniformity flag and per-frame end markers.
// The axial/centre set is delayed by ALIGN cycles so that it lines up with
// the interpolator output of the same pixel.
module lbp_code_gen #(
  parameter int ALIGN     = 3,
  parameter int PIX_COUNT = 65536,
  parameter int U_MAX     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done_i,
  input  logic [7:0]  center_i,
  input  logic [7:0]  n0_i,
  input  logic [7:0]  n2_i,
  input  logic [7:0]  n4_i,
  input  logic [7:0]  n6_i,
  input  logic        interp_done_i,
  input  logic [31:0] d1_i,
  input  logic [31:0] d3_i,
  input  logic [31:0] d5_i,
  input  logic [31:0] d7_i,
  output logic [7:0]  code_o,
  output logic        uniform_o,
  output logic        done_o,
  output logic        frame_done_o,
  output logic        align_err_o
);

  localparam int              CNT_W    = (PIX_COUNT > 1) ? $clog2(PIX_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_COUNT - 1);
  localparam logic [3:0]       U_MAX_C  = 4'(U_MAX);

  // Round a Q16 sample to the nearest integer and clamp it to 8 bits.
  function automatic logic [7:0] round_sat(input logic [31:0] d);
    logic [16:0] p;
    p = 17'(({1'b0, d} + 33'h0_0000_8000) >> 16);
    if (p > 17'd255) begin
      round_sat = 8'hFF;
    end else begin
      round_sat = p[7:0];
    end
  endfunction

  // Count the bit changes around the circular 8-bit pattern.
  function automatic logic [3:0] count_trans(input logic [7:0] b);
    logic [3:0] t;
    t = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i] != b[(i + 1) % 8]) begin
        t = t + 4'd1;
      end else begin
        t = t;
      end
    end
    count_trans = t;
  endfunction

  // ---------------------------------------------------------------------------
  // Delay line for {done, centre, n0, n2, n4, n6}; the last stage is the tap
  // ---------------------------------------------------------------------------
  logic [ALIGN-1:0] dl_vld_q;
  logic [39:0]      dl_pix_q [ALIGN];
  logic             tap_vld_s;
  logic [39:0]      tap_pix_s;

  assign tap_vld_s = dl_vld_q[ALIGN-1];
  assign tap_pix_s = dl_pix_q[ALIGN-1];

  // Shift the axial/centre set one stage per cycle and never stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld_q <= '0;
      for (int i = 0; i < ALIGN; i++) begin
        dl_pix_q[i] <= 40'd0;
      end
    end else begin
      dl_vld_q[0] <= done_i;
      dl_pix_q[0] <= {center_i, n0_i, n2_i, n4_i, n6_i};
      for (int i = 1; i < ALIGN; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_pix_q[i] <= dl_pix_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic             s1_vld_q, s1_vld_d;
  logic [7:0]       s1_ctr_q, s1_ctr_d;
  logic [7:0]       s1_nb_q [8];
  logic [7:0]       s1_nb_d [8];
  logic             s2_vld_q, s2_vld_d;
  logic [7:0]       s2_bits_q, s2_bits_d;
  logic [7:0]       code_q, code_d;
  logic             uniform_q, uniform_d;
  logic             done_q, done_d;
  logic             frame_done_q, frame_done_d;
  logic             align_err_q, align_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stage 1 next state: load rounded diagonals and the aligned axial set.
  // Neighbours are stored in bit order b0..b7.
  always_comb begin
    s1_vld_d = interp_done_i;
    s1_ctr_d = s1_ctr_q;
    for (int i = 0; i < 8; i++) begin
      s1_nb_d[i] = s1_nb_q[i];
    end
    if (interp_done_i) begin
      s1_ctr_d   = tap_pix_s[39:32];
      s1_nb_d[0] = tap_pix_s[31:24];
      s1_nb_d[1] = round_sat(d1_i);
      s1_nb_d[2] = tap_pix_s[23:16];
      s1_nb_d[3] = round_sat(d3_i);
      s1_nb_d[4] = tap_pix_s[15:8];
      s1_nb_d[5] = round_sat(d5_i);
      s1_nb_d[6] = tap_pix_s[7:0];
      s1_nb_d[7] = round_sat(d7_i);
    end else begin
      s1_ctr_d = s1_ctr_q;
    end
  end

  // Stage 2 next state: threshold each neighbour against the centre.
  always_comb begin
    s2_vld_d  = s1_vld_q;
    s2_bits_d = s2_bits_q;
    if (s1_vld_q) begin
      for (int i = 0; i < 8; i++) begin
        s2_bits_d[i] = (s1_nb_q[i] >= s1_ctr_q);
      end
    end else begin
      s2_bits_d = s2_bits_q;
    end
  end

  // Stage 3 next state: publish the code, classify uniformity and
  // advance the frame position.
  always_comb begin
    code_d       = code_q;
    uniform_d    = uniform_q;
    done_d       = 1'b0;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    if (s2_vld_q) begin
      code_d    = s2_bits_q;
      uniform_d = (count_trans(s2_bits_q) <= U_MAX_C);
      done_d    = 1'b1;
      if (cnt_q == CNT_LAST) begin
        frame_done_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // The error flag is sticky: it stays set once the tap and interpolator valids disagree.
  always_comb begin
    if (tap_vld_s != interp_done_i) begin
      align_err_d = 1'b1;
    end else begin
      align_err_d = align_err_q;
    end
  end

  // Register all pipeline stages; reset discards in-flight pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_ctr_q     <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        s1_nb_q[i] <= 8'd0;
      end
      s2_vld_q     <= 1'b0;
      s2_bits_q    <= 8'd0;
      code_q       <= 8'd0;
      uniform_q    <= 1'b0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      align_err_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_ctr_q     <= s1_ctr_d;
      for (int i = 0; i < 8; i++) begin
        s1_nb_q[i] <= s1_nb_d[i];
      end
      s2_vld_q     <= s2_vld_d;
      s2_bits_q    <= s2_bits_d;
      code_q       <= code_d;
      uniform_q    <= uniform_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
      align_err_q  <= align_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign code_o       = code_q;
  assign uniform_o    = uniform_q;
  assign done_o       = done_q;
  assign frame_done_o = frame_done_q;
  assign align_err_o  = align_err_q;

endmodule

// File: tb/tb_lbp_code_gen.sv
// Directed testbench for lbp_code_gen (PIX_COUNT reduced to 4 for frame tests).
module tb_lbp_code_gen;

  localparam int ALIGN = 3;
  localparam int PIXC  = 4;

  typedef struct packed {
    logic [7:0]  c, n0, n2, n4, n6;
    logic [31:0] d1, d3, d5, d7;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done_i = 1'b0;
  logic [7:0]  center_i = 8'd0, n0_i = 8'd0, n2_i = 8'd0, n4_i = 8'd0, n6_i = 8'd0;
  logic        interp_done_i = 1'b0;
  logic [31:0] d1_i = 32'd0, d3_i = 32'd0, d5_i = 32'd0, d7_i = 32'd0;
  logic [7:0]  code_o;
  logic        uniform_o, done_o, frame_done_o, align_err_o;

  lbp_code_gen #(.ALIGN(ALIGN), .PIX_COUNT(PIXC), .U_MAX(2)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .center_i(center_i),
    .n0_i(n0_i), .n2_i(n2_i), .n4_i(n4_i), .n6_i(n6_i),
    .interp_done_i(interp_done_i), .d1_i(d1_i), .d3_i(d3_i), .d5_i(d5_i), .d7_i(d7_i),
    .code_o(code_o), .uniform_o(uniform_o), .done_o(done_o),
    .frame_done_o(frame_done_o), .align_err_o(align_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int stray_fd = 0;
  int frame_base = 0;
  int first_e = 0;

  pix_t       stim [$];
  logic [7:0] got_code [$];
  logic       got_uni [$];
  logic       got_fd [$];
  int         got_cyc [$];

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output pixel away from the active edge.
  always @(negedge clk) begin
    if (done_o) begin
      got_code.push_back(code_o);
      got_uni.push_back(uniform_o);
      got_fd.push_back(frame_done_o);
      got_cyc.push_back(cyc);
    end
    if (frame_done_o && !done_o) stray_fd <= stray_fd + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference rounding: integer part plus the half bit, clamped at 255.
  function automatic logic [7:0] ref_rnd(input logic [31:0] d);
    logic [15:0] hi;
    hi = d[31:16];
    if (hi >= 16'd255) return 8'hFF;
    return 8'(hi + {15'd0, d[15]});
  endfunction

  function automatic logic [7:0] ref_code(input pix_t p);
    logic [7:0] r;
    r[0] = p.n0 >= p.c;          r[1] = ref_rnd(p.d1) >= p.c;
    r[2] = p.n2 >= p.c;          r[3] = ref_rnd(p.d3) >= p.c;
    r[4] = p.n4 >= p.c;          r[5] = ref_rnd(p.d5) >= p.c;
    r[6] = p.n6 >= p.c;          r[7] = ref_rnd(p.d7) >= p.c;
    return r;
  endfunction

  function automatic logic ref_uni(input logic [7:0] c);
    return $countones(c ^ {c[0], c[7:1]}) <= 2;
  endfunction

  function automatic pix_t gen_pix(input int k, input int salt);
    pix_t p;
    p.c  = 8'(30 + 20 * k + salt);
    p.n0 = 8'(k * 53 + salt);
    p.n2 = p.c;
    p.n4 = 8'(p.c - 8'd1);
    p.n6 = 8'(255 - k * 17);
    p.d1 = {8'd0, 8'(p.c), 16'(k * 4000)};
    p.d3 = {8'd0, 8'(p.c - 8'd1), 16'h8000};
    p.d5 = {16'(k * 40 + salt), 16'h7FFF};
    p.d7 = {8'd0, 8'(k * 25 + salt), 16'h0000};
    return p;
  endfunction

  task automatic clear_got();
    got_code.delete(); got_uni.delete(); got_fd.delete(); got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; done_i = 1'b0; interp_done_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    frame_base = 0;
  endtask

  // Drive the stim queue: axial set at cycle k, diagonals ALIGN cycles later.
  task automatic run_burst();
    int n;
    n = stim.size();
    for (int k = 0; k < n + ALIGN; k++) begin
      if (k < n) begin
        done_i = 1'b1; center_i = stim[k].c;
        n0_i = stim[k].n0; n2_i = stim[k].n2; n4_i = stim[k].n4; n6_i = stim[k].n6;
      end else begin
        done_i = 1'b0;
      end
      if (k >= ALIGN) begin
        interp_done_i = 1'b1;
        d1_i = stim[k-ALIGN].d1; d3_i = stim[k-ALIGN].d3;
        d5_i = stim[k-ALIGN].d5; d7_i = stim[k-ALIGN].d7;
      end else begin
        interp_done_i = 1'b0;
      end
      @(posedge clk); #1;
      if (k == ALIGN) first_e = cyc;
    end
    done_i = 1'b0; interp_done_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Compare captured outputs against the model and the frame position.
  task automatic verify(input string tag);
    check_eq({tag, " count"}, got_code.size(), stim.size());
    for (int i = 0; i < stim.size() && i < got_code.size(); i++) begin
      check_eq($sformatf("%s code[%0d]", tag, i), {24'd0, got_code[i]}, {24'd0, ref_code(stim[i])});
      check_eq($sformatf("%s uni[%0d]", tag, i), {31'd0, got_uni[i]}, {31'd0, ref_uni(ref_code(stim[i]))});
      check_eq($sformatf("%s fd[%0d]", tag, i), {31'd0, got_fd[i]},
               {31'd0, ((frame_base + i) % PIXC) == (PIXC - 1)});
      check_eq($sformatf("%s cyc[%0d]", tag, i), got_cyc[i], got_cyc[0] + i);
    end
    frame_base += got_code.size();
  endtask

  logic [7:0] exp_code [4];
  logic       exp_uni [4];
  pix_t       p;

  initial begin
    do_reset();
    check_eq("rst code", {24'd0, code_o}, 32'd0);
    check_eq("rst uniform", {31'd0, uniform_o}, 32'd0);
    check_eq("rst done", {31'd0, done_o}, 32'd0);
    check_eq("rst frame_done", {31'd0, frame_done_o}, 32'd0);
    check_eq("rst align_err", {31'd0, align_err_o}, 32'd0);

    // Hand-computed vectors: tie/round-down/round-up/saturate, all-zero,
    // single-bit, and 0x00FEFE02 rounding up to 255.
    clear_got(); stim.delete();
    stim.push_back('{8'd100, 8'd100, 8'd99, 8'd200, 8'd50,
                     32'h0064_0000, 32'h0063_7FFF, 32'h0063_8000, 32'h0100_0000});
    stim.push_back('{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 32'd0, 32'd0, 32'd0, 32'd0});
    stim.push_back('{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 32'd0, 32'd0, 32'd0, 32'd0});
    stim.push_back('{8'd255, 8'd0, 8'd0, 8'd0, 8'd0,
                     32'h00FE_FE02, 32'h00FE_FE02, 32'h00FE_FE02, 32'h00FE_FE02});
    exp_code = '{8'hB3, 8'hFF, 8'h01, 8'hAA};
    exp_uni  = '{1'b0, 1'b1, 1'b1, 1'b0};
    run_burst();
    check_eq("directed count", got_code.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_code.size(); i++) begin
      check_eq($sformatf("directed code[%0d]", i), {24'd0, got_code[i]}, {24'd0, exp_code[i]});
      check_eq($sformatf("directed uni[%0d]", i), {31'd0, got_uni[i]}, {31'd0, exp_uni[i]});
      check_eq($sformatf("directed fd[%0d]", i), {31'd0, got_fd[i]}, {31'd0, i == 3});
    end
    if (got_cyc.size() > 0) check_eq("latency", got_cyc[0], first_e + 2);
    else check_eq("latency no output", 32'd0, 32'd1);
    check_eq("hold code", {24'd0, code_o}, 32'h0000_00AA);
    check_eq("hold done low", {31'd0, done_o}, 32'd0);
    check_eq("directed align_err", {31'd0, align_err_o}, 32'd0);

    // Nine pixels from reset: frame markers on the 4th and 8th only.
    do_reset();
    clear_got(); stim.delete();
    for (int k = 0; k < 9; k++) stim.push_back(gen_pix(k, 3));
    run_burst();
    verify("nine");

    // Ten back-to-back pixels with distinct centres, continuing the frame.
    clear_got(); stim.delete();
    for (int k = 0; k < 10; k++) stim.push_back(gen_pix(k, 0));
    run_burst();
    verify("ten");
    check_eq("ten align_err", {31'd0, align_err_o}, 32'd0);

    // Reset one cycle after interp_done_i: the in-flight pixel is discarded.
    clear_got();
    p = gen_pix(2, 1);
    done_i = 1'b1; center_i = p.c; n0_i = p.n0; n2_i = p.n2; n4_i = p.n4; n6_i = p.n6;
    @(posedge clk); #1;
    done_i = 1'b0;
    repeat (ALIGN - 1) begin @(posedge clk); #1; end
    interp_done_i = 1'b1; d1_i = p.d1; d3_i = p.d3; d5_i = p.d5; d7_i = p.d7;
    @(posedge clk); #1;
    interp_done_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; frame_base = 0;
    check_eq("midrst code", {24'd0, code_o}, 32'd0);
    check_eq("midrst uniform", {31'd0, uniform_o}, 32'd0);
    check_eq("midrst done", {31'd0, done_o}, 32'd0);
    check_eq("midrst frame_done", {31'd0, frame_done_o}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check_eq("midrst no done", got_code.size(), 32'd0);
    stim.delete();
    for (int k = 0; k < 4; k++) stim.push_back(gen_pix(k, 9));
    run_burst();
    verify("restart");

    // Lone interp_done_i: error flag sets next cycle and stays set.
    check_eq("pre align_err", {31'd0, align_err_o}, 32'd0);
    interp_done_i = 1'b1;
    @(posedge clk); #1;
    interp_done_i = 1'b0;
    check_eq("align_err set", {31'd0, align_err_o}, 32'd1);
    stim.delete();
    for (int k = 0; k < 3; k++) stim.push_back(gen_pix(k, 5));
    run_burst();
    check_eq("align_err sticky", {31'd0, align_err_o}, 32'd1);
    do_reset();
    check_eq("align_err cleared", {31'd0, align_err_o}, 32'd0);

    check_eq("stray frame_done", stray_fd, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
